// File: rtl/sram_slot_arbiter.sv
// Time-slot controller for the shared asynchronous 16-bit SRAM.
// Client 0 (display) owns the leading windows of each frame; the rest are round-robin.
module sram_slot_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int NUM_CLIENTS   = 4,
  parameter int SLOT_PERIOD   = 8,
  parameter int FIXED_WINDOWS = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          slot_sync,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [2*NUM_CLIENTS-1:0]      be,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] addr,
  input  logic [16*NUM_CLIENTS-1:0]     wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rd_valid,
  output logic [15:0]                   rdata,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  inout  wire  [15:0]                   SRAM_DQ,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N
);

  localparam int SW = $clog2(SLOT_PERIOD);
  localparam int CW = $clog2(NUM_CLIENTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOT_PERIOD - 1);

  if ((SLOT_PERIOD % 2) != 0 || SLOT_PERIOD < 4 || SLOT_PERIOD > 64 ||
      FIXED_WINDOWS < 0 || FIXED_WINDOWS > SLOT_PERIOD / 2 ||
      NUM_CLIENTS < 2 || NUM_CLIENTS > 8) begin : g_bad_param
    $error("sram_slot_arbiter: illegal parameter combination");
  end

  logic [SW-1:0]  slot_cnt, slot_nxt;
  logic           sync_pend, sync_pend_nxt;
  logic [CW-1:0]  rr, cur;
  logic           cur_act, cur_we;
  logic [15:0]    dq_out;
  logic           dq_oe;

  logic           win_found, win_rr;
  logic [CW-1:0]  win_idx, cand;
  logic [ADDR_W-1:0] sel_addr;
  logic           sel_we;
  logic [1:0]     sel_be;
  logic [15:0]    sel_wdata;

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  // A sync seen in phase A is deferred so the access in flight always finishes its phase B.
  always_comb begin
    slot_nxt      = slot_cnt + 1'b1;
    sync_pend_nxt = sync_pend;
    if (slot_cnt[0]) begin
      sync_pend_nxt = 1'b0;
      if (sync_pend || slot_sync || slot_cnt == LAST_SLOT) slot_nxt = '0;
    end else if (slot_sync) begin
      sync_pend_nxt = 1'b1;
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_rr    = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if ((int'(slot_nxt) / 2) < FIXED_WINDOWS && req[0]) begin
      win_found = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_CLIENTS; i++) begin
        cand = CW'((int'(rr) + i) % NUM_CLIENTS);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_rr    = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      if (win_idx == CW'(c)) begin
        sel_addr  = addr[c*ADDR_W +: ADDR_W];
        sel_we    = we[c];
        sel_be    = be[c*2 +: 2];
        sel_wdata = wdata[c*16 +: 16];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_cnt  <= '0;
      sync_pend <= 1'b0;
      rr        <= CW'(NUM_CLIENTS - 1);
      cur       <= '0;
      cur_act   <= 1'b0;
      cur_we    <= 1'b0;
      gnt       <= '0;
      rd_valid  <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      slot_cnt  <= slot_nxt;
      sync_pend <= sync_pend_nxt;
      gnt       <= '0;
      rd_valid  <= '0;
      if (slot_cnt[0]) begin
        // End of phase B: retire the read, then start the next window.
        if (cur_act && !cur_we) begin
          rdata         <= SRAM_DQ;
          rd_valid[cur] <= 1'b1;
        end
        cur_act   <= win_found;
        cur       <= win_idx;
        SRAM_CE_N <= 1'b0;
        if (win_found) begin
          gnt[win_idx] <= 1'b1;
          if (win_rr) rr <= win_idx;
          SRAM_ADDR <= sel_addr;
          cur_we    <= sel_we;
          if (sel_we) begin
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b0;
            SRAM_UB_N <= ~sel_be[1];
            SRAM_LB_N <= ~sel_be[0];
            dq_out    <= sel_wdata;
            dq_oe     <= 1'b1;
          end else begin
            SRAM_OE_N <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            dq_oe     <= 1'b0;
          end
        end else begin
          cur_we    <= 1'b0;
          SRAM_OE_N <= 1'b0;
          SRAM_WE_N <= 1'b1;
          SRAM_UB_N <= 1'b0;
          SRAM_LB_N <= 1'b0;
          dq_oe     <= 1'b0;
        end
      end else begin
        // Phase B: write data stays on the bus as hold time after WE_N rises.
        SRAM_WE_N <= 1'b1;
        if (!cur_act) begin
          SRAM_CE_N <= 1'b0;
          SRAM_OE_N <= 1'b0;
          SRAM_UB_N <= 1'b0;
          SRAM_LB_N <= 1'b0;
          dq_oe     <= 1'b0;
        end
      end
    end
  end

endmodule
